// File: rtl/uart_cmd_slave.sv
// uart_cmd_slave: UART command responder for the register bus.
//
// Receives 8-bit frames (start, d0..d7 LSB first, odd parity, stop) on rx.
// Byte 0 carries RW in bit 7 and the register address in bits 6:0. A write
// command is followed by one data byte. Each command becomes a single-cycle
// register-bus access. A read returns the data byte on tx after one idle bit
// period.
//
// Build option: define UART_SLAVE_PARITY_CHECK_EN to reject frames whose
// received parity is wrong. Without it, the parity bit is sampled and ignored.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   rx           serial input (asynchronous, idle high)
//   tx           serial output (registered, idle high)
//   reg_wr_en    one-cycle write strobe
//   reg_rd_en    one-cycle read strobe
//   reg_addr     access address, held until the next command
//   reg_wdata    write data, valid with reg_wr_en
//   reg_rdata    read data, sampled while reg_rvalid is high
//   reg_rvalid   read data valid
//   frame_err    one-cycle pulse on stop, parity, write-timeout or read-timeout error
//   busy         low only when the decoder waits for a command and the receiver is idle
module uart_cmd_slave #(
   parameter int unsigned CLKS_PER_BIT    = 434,
   parameter int unsigned ADDR_WIDTH      = 7,
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned WR_TIMEOUT_BITS = 32,
   parameter int unsigned RD_TIMEOUT_CLKS = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx,
   output logic                  tx,
   output logic                  reg_wr_en,
   output logic                  reg_rd_en,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [DATA_WIDTH-1:0] reg_wdata,
   input  logic [DATA_WIDTH-1:0] reg_rdata,
   input  logic                  reg_rvalid,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int unsigned Half          = CLKS_PER_BIT / 2;
   localparam int unsigned CntW          = $clog2(CLKS_PER_BIT);
   localparam int unsigned BitW          = $clog2(DATA_WIDTH);
   localparam int unsigned WrTimeoutClks = WR_TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned TmrMax        = (WrTimeoutClks > RD_TIMEOUT_CLKS) ?
                                           WrTimeoutClks : RD_TIMEOUT_CLKS;
   localparam int unsigned TmrW          = $clog2(TmrMax + 1);

`ifdef UART_SLAVE_PARITY_CHECK_EN
   localparam bit ParityCheck = 1'b1;
`else
   localparam bit ParityCheck = 1'b0;
`endif

   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxPar, RxStop} rx_state_e;
   typedef enum logic [3:0] {
      CmdWait, WdataWait, Wr, Rd, RdWait, Turn, TxStart, TxData, TxPar, TxStop
   } dec_state_e;

   // ------------------------------------------------------------------ receiver
   logic                  rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_e             rx_q, rx_d;
   logic [CntW-1:0]       rx_cnt_q, rx_cnt_d;
   logic [BitW-1:0]       rx_bit_q, rx_bit_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic                  rx_par_bad_q, rx_par_bad_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  rx_perr_q, rx_perr_d;
   logic                  rx_err;
   logic                  rx_sample;

   assign rx_sample = (rx_cnt_q == CntW'(Half));

   always_comb begin
      rx_d         = rx_q;
      rx_cnt_d     = (rx_cnt_q == CntW'(CLKS_PER_BIT - 1)) ? '0 : rx_cnt_q + CntW'(1);
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      rx_par_bad_d = rx_par_bad_q;
      rx_valid_d   = 1'b0;
      rx_perr_d    = 1'b0;
      rx_err       = 1'b0;
      unique case (rx_q)
         RxIdle: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_sync_q) rx_d = RxStart;
         end
         RxStart: begin
            if (rx_sample) begin
               // A start bit that is already high again at mid-bit was noise.
               if (rx_sync_q) begin
                  rx_d = RxIdle;
               end else begin
                  rx_d     = RxData;
                  rx_bit_d = '0;
               end
            end
         end
         RxData: begin
            if (rx_sample) begin
               rx_shift_d = {rx_sync_q, rx_shift_q[DATA_WIDTH-1:1]};
               if (rx_bit_q == BitW'(DATA_WIDTH - 1)) rx_d = RxPar;
               else rx_bit_d = rx_bit_q + BitW'(1);
            end
         end
         RxPar: begin
            if (rx_sample) begin
               rx_par_bad_d = ParityCheck && (rx_sync_q != ~^rx_shift_q);
               rx_d         = RxStop;
            end
         end
         RxStop: begin
            if (rx_sample) begin
               // Back to idle at mid-stop so the next start edge is not missed.
               rx_d = RxIdle;
               if (!rx_sync_q) begin
                  rx_err = 1'b1;
               end else if (rx_par_bad_q) begin
                  rx_err    = 1'b1;
                  rx_perr_d = 1'b1;
               end else begin
                  rx_valid_d = 1'b1;
               end
            end
         end
         default: rx_d = RxIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
         rx_q         <= RxIdle;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         rx_par_bad_q <= 1'b0;
         rx_valid_q   <= 1'b0;
         rx_perr_q    <= 1'b0;
      end else begin
         rx_meta_q    <= rx;
         rx_sync_q    <= rx_meta_q;
         rx_prev_q    <= rx_sync_q;
         rx_q         <= rx_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         rx_par_bad_q <= rx_par_bad_d;
         rx_valid_q   <= rx_valid_d;
         rx_perr_q    <= rx_perr_d;
      end
   end

   // ------------------------------------------------------- decoder/transmitter
   dec_state_e            dec_q, dec_d;
   logic [TmrW-1:0]       tmr_q, tmr_d;
   logic [BitW-1:0]       tx_bit_q, tx_bit_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  tx_q, tx_d;
   logic                  frame_err_q, frame_err_d;
   logic                  dec_err;
   logic                  bit_end;

   assign bit_end = (tmr_q == TmrW'(CLKS_PER_BIT - 1));

   always_comb begin
      dec_d    = dec_q;
      tmr_d    = '0;
      tx_bit_d = tx_bit_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      dec_err  = 1'b0;
      unique case (dec_q)
         CmdWait: begin
            if (rx_valid_q) begin
               addr_d = rx_shift_q[ADDR_WIDTH-1:0];
               dec_d  = rx_shift_q[DATA_WIDTH-1] ? WdataWait : Rd;
            end
         end
         WdataWait: begin
            if (rx_perr_q) begin
               dec_d = CmdWait;
            end else if (rx_valid_q) begin
               wdata_d = rx_shift_q;
               dec_d   = Wr;
            end else if (rx_q != RxIdle) begin
               // Timeout only covers the gap before the data byte starts.
               tmr_d = tmr_q;
            end else if (tmr_q == TmrW'(WrTimeoutClks - 1)) begin
               dec_err = 1'b1;
               dec_d   = CmdWait;
            end else begin
               tmr_d = tmr_q + TmrW'(1);
            end
         end
         Wr: dec_d = CmdWait;
         Rd: begin
            if (reg_rvalid) begin
               rdata_d = reg_rdata;
               dec_d   = Turn;
            end else begin
               tmr_d = TmrW'(1);
               dec_d = RdWait;
            end
         end
         RdWait: begin
            if (reg_rvalid) begin
               rdata_d = reg_rdata;
               dec_d   = Turn;
            end else if (tmr_q == TmrW'(RD_TIMEOUT_CLKS - 1)) begin
               rdata_d = '1;
               dec_err = 1'b1;
               dec_d   = Turn;
            end else begin
               tmr_d = tmr_q + TmrW'(1);
            end
         end
         Turn: begin
            if (bit_end) dec_d = TxStart;
            else tmr_d = tmr_q + TmrW'(1);
         end
         TxStart: begin
            if (bit_end) begin
               dec_d    = TxData;
               tx_bit_d = '0;
            end else begin
               tmr_d = tmr_q + TmrW'(1);
            end
         end
         TxData: begin
            if (bit_end) begin
               if (tx_bit_q == BitW'(DATA_WIDTH - 1)) dec_d = TxPar;
               else tx_bit_d = tx_bit_q + BitW'(1);
            end else begin
               tmr_d = tmr_q + TmrW'(1);
            end
         end
         TxPar: begin
            if (bit_end) dec_d = TxStop;
            else tmr_d = tmr_q + TmrW'(1);
         end
         TxStop: begin
            if (bit_end) dec_d = CmdWait;
            else tmr_d = tmr_q + TmrW'(1);
         end
         default: dec_d = CmdWait;
      endcase

      // tx follows the next state so the line changes in step with the FSM.
      unique case (dec_d)
         TxStart: tx_d = 1'b0;
         TxData:  tx_d = rdata_q[tx_bit_d];
         TxPar:   tx_d = ~^rdata_q;
         default: tx_d = 1'b1;
      endcase

      frame_err_d = rx_err | dec_err;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_q       <= CmdWait;
         tmr_q       <= '0;
         tx_bit_q    <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         tx_q        <= 1'b1;
         frame_err_q <= 1'b0;
      end else begin
         dec_q       <= dec_d;
         tmr_q       <= tmr_d;
         tx_bit_q    <= tx_bit_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         tx_q        <= tx_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign tx        = tx_q;
   assign reg_wr_en = (dec_q == Wr);
   assign reg_rd_en = (dec_q == Rd);
   assign reg_addr  = addr_q;
   assign reg_wdata = wdata_q;
   assign frame_err = frame_err_q;
   assign busy      = (dec_q != CmdWait) || (rx_q != RxIdle);

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Directed bench for uart_cmd_slave. Expected register writes and transmitted
// bytes are queued when stimulus is driven and compared when the DUT produces them.
module tb_uart_cmd_slave;

   localparam int CPB    = 240;
   localparam int RD_TO  = 16;
   localparam int WR_TO  = 32;

   typedef struct packed {
      logic [6:0] addr;
      logic [7:0] data;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       tx;
   logic       reg_wr_en;
   logic       reg_rd_en;
   logic [6:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic       reg_rvalid;
   logic       frame_err;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int wr_seen = 0;
   int rd_seen = 0;
   int fe_cnt = 0;

   wr_t        wr_q[$];
   logic [7:0] tx_q[$];

   uart_cmd_slave #(
      .CLKS_PER_BIT    (CPB),
      .ADDR_WIDTH      (7),
      .DATA_WIDTH      (8),
      .WR_TIMEOUT_BITS (WR_TO),
      .RD_TIMEOUT_CLKS (RD_TO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .tx         (tx),
      .reg_wr_en  (reg_wr_en),
      .reg_rd_en  (reg_rd_en),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_rdata  (reg_rdata),
      .reg_rvalid (reg_rvalid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Bus monitor: every write strobe must match the oldest queued write.
   always @(negedge clk) begin : bus_mon
      wr_t e;
      if (rst_n === 1'b1) begin
         if (reg_wr_en === 1'b1) begin
            wr_seen++;
            if (wr_q.size() > 0) e = wr_q.pop_front();
            else e = 'x;
            chk("wr_addr", {25'd0, reg_addr}, {25'd0, e.addr});
            chk("wr_data", {24'd0, reg_wdata}, {24'd0, e.data});
         end
         if (reg_rd_en === 1'b1) rd_seen++;
         if (frame_err === 1'b1) fe_cnt++;
      end
   end

   task automatic send_byte(input logic [7:0] d, input logic bad_par);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (CPB) @(negedge clk);
      end
      rx = (~^d) ^ bad_par;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   // Called on the first negedge where tx is low; samples every bit at mid-period.
   task automatic recv_check();
      logic [7:0] d;
      logic [7:0] e;
      logic       st, p, s;
      repeat (CPB / 2) @(negedge clk);
      st = tx;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         d[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      p = tx;
      repeat (CPB) @(negedge clk);
      s = tx;
      if (tx_q.size() > 0) e = tx_q.pop_front();
      else e = 'x;
      chk("tx_start_bit", {31'd0, st}, 32'd0);
      chk("tx_data", {24'd0, d}, {24'd0, e});
      chk("tx_parity", {31'd0, p}, {31'd0, ~^e});
      chk("tx_stop", {31'd0, s}, 32'd1);
      repeat (CPB) @(negedge clk);
   endtask

   // dly < 0: never answer, expect the read timeout and a 0xFF reply.
   task automatic serve_read(input logic [6:0] a, input logic [7:0] d, input int dly);
      int k;
      k = 0;
      while (reg_rd_en !== 1'b1 && k < 16 * CPB) begin
         @(negedge clk);
         k++;
      end
      chk("rd_en_seen", {31'd0, reg_rd_en}, 32'd1);
      chk("rd_addr", {25'd0, reg_addr}, {25'd0, a});
      if (dly >= 0) begin
         repeat (dly) @(negedge clk);
         reg_rdata  = d;
         reg_rvalid = 1'b1;
         tx_q.push_back(d);
         @(negedge clk);
         reg_rvalid = 1'b0;
         k = 1;
         while (tx !== 1'b0 && k < 4 * CPB) begin
            @(negedge clk);
            k++;
         end
         chk("tx_start_latency", k, CPB + 1);
      end else begin
         tx_q.push_back(8'hFF);
         k = 0;
         while (frame_err !== 1'b1 && k < 4 * RD_TO) begin
            @(negedge clk);
            k++;
         end
         chk("rd_timeout_cycle", k, RD_TO);
         k = 0;
         while (tx !== 1'b0 && k < 4 * CPB) begin
            @(negedge clk);
            k++;
         end
         chk("tx_start_seen", {31'd0, tx}, 32'd0);
      end
      recv_check();
   endtask

   task automatic read_txn(input logic [6:0] a, input logic [7:0] d, input int dly);
      fork
         send_byte({1'b0, a}, 1'b0);
         serve_read(a, d, dly);
      join
   endtask

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s_fe, s_wr, s_rd, k;
      rx         = 1'b1;
      reg_rdata  = 8'h00;
      reg_rvalid = 1'b0;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
      chk("rst_rd_en", {31'd0, reg_rd_en}, 32'd0);
      chk("rst_addr", {25'd0, reg_addr}, 32'd0);
      chk("rst_wdata", {24'd0, reg_wdata}, 32'd0);
      chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Write 0x85 / 0x3C with a 100-cycle gap.
      s_fe = fe_cnt;
      s_wr = wr_seen;
      wr_q.push_back('{addr: 7'h05, data: 8'h3C});
      send_byte(8'h85, 1'b0);
      repeat (100) @(negedge clk);
      send_byte(8'h3C, 1'b0);
      repeat (CPB) @(negedge clk);
      chk("wr_count", wr_seen - s_wr, 1);
      chk("wr_pending", wr_q.size(), 0);
      chk("wr_addr_held", {25'd0, reg_addr}, 32'h05);
      chk("wr_wdata_held", {24'd0, reg_wdata}, 32'h3C);
      chk("wr_no_frame_err", fe_cnt - s_fe, 0);
      chk("wr_idle_busy", {31'd0, busy}, 32'd0);

      // Read 0x12, data 0xA5 two cycles after the strobe.
      s_fe = fe_cnt;
      read_txn(7'h12, 8'hA5, 2);
      chk("rd_no_frame_err", fe_cnt - s_fe, 0);
      chk("rd_addr_held", {25'd0, reg_addr}, 32'h12);

      // Read with no response: timeout, reply 0xFF.
      s_fe = fe_cnt;
      read_txn(7'h34, 8'h00, -1);
      chk("rdto_frame_err", fe_cnt - s_fe, 1);

      // Write command with a bad parity bit.
      s_fe = fe_cnt;
      s_wr = wr_seen;
      send_byte(8'h85, 1'b1);
`ifdef UART_SLAVE_PARITY_CHECK_EN
      repeat (CPB) @(negedge clk);
      chk("par_frame_err", fe_cnt - s_fe, 1);
      chk("par_no_write", wr_seen - s_wr, 0);
      chk("par_busy", {31'd0, busy}, 32'd0);
`else
      wr_q.push_back('{addr: 7'h05, data: 8'h77});
      repeat (100) @(negedge clk);
      send_byte(8'h77, 1'b0);
      repeat (CPB) @(negedge clk);
      chk("par_ignored_write", wr_seen - s_wr, 1);
      chk("par_no_frame_err", fe_cnt - s_fe, 0);
      chk("par_wdata", {24'd0, reg_wdata}, 32'h77);
`endif

      // rx low for 100 cycles, less than half a bit: a glitch.
      s_fe = fe_cnt;
      s_wr = wr_seen;
      s_rd = rd_seen;
      rx = 1'b0;
      repeat (100) @(negedge clk);
      chk("glitch_busy_in_start", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      chk("glitch_no_frame_err", fe_cnt - s_fe, 0);
      chk("glitch_no_access", (wr_seen - s_wr) + (rd_seen - s_rd), 0);
      chk("glitch_busy", {31'd0, busy}, 32'd0);

      // Write command then silence: write timeout.
      s_fe = fe_cnt;
      s_wr = wr_seen;
      send_byte(8'h85, 1'b0);
      k = 0;
      while (frame_err !== 1'b1 && k < (WR_TO + 8) * CPB) begin
         @(negedge clk);
         k++;
      end
      chk("wrto_frame_err", {31'd0, frame_err}, 32'd1);
      chk("wrto_window", {31'd0, (k >= (WR_TO - 1) * CPB) && (k <= WR_TO * CPB)}, 32'd1);
      repeat (2) @(negedge clk);
      chk("wrto_busy", {31'd0, busy}, 32'd0);
      chk("wrto_no_write", wr_seen - s_wr, 0);
      chk("wrto_err_count", fe_cnt - s_fe, 1);

      // Reset in the middle of a transmitted data bit.
      fork
         send_byte(8'h40, 1'b0);
         begin
            k = 0;
            while (reg_rd_en !== 1'b1 && k < 16 * CPB) begin
               @(negedge clk);
               k++;
            end
            chk("rst_rd_en_seen", {31'd0, reg_rd_en}, 32'd1);
            reg_rdata  = 8'h00;
            reg_rvalid = 1'b1;
            @(negedge clk);
            reg_rvalid = 1'b0;
            k = 0;
            while (tx !== 1'b0 && k < 4 * CPB) begin
               @(negedge clk);
               k++;
            end
            repeat (CPB + CPB / 2) @(negedge clk);
            chk("tx_low_before_reset", {31'd0, tx}, 32'd0);
            rst_n = 1'b0;
            #1;
            chk("tx_async_reset", {31'd0, tx}, 32'd1);
            chk("busy_async_reset", {31'd0, busy}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
         end
      join
      repeat (10) @(negedge clk);

      s_fe = fe_cnt;
      read_txn(7'h22, 8'h5A, 1);
      chk("post_reset_no_frame_err", fe_cnt - s_fe, 0);
      chk("tx_queue_drained", tx_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
